fft_twiddle_gen: RTL and testbench

//  Twiddle-factor source for the radix-4 twiddle multiplier stage: drives the W1/W2/W3 inputs of the

---
 rtl/fft_twiddle_gen.sv | 217 +++++++++++++++++++++
 tb/tb_fft_twiddle_gen.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fft_twiddle_gen.sv
// Radix-4 DIF twiddle source: one (W^e, W^2e, W^3e) triple per butterfly, two-cycle latency.
// Build option TWIDDLE_QUARTER_ROM_EN: quarter-wave cosine table with quadrant folding instead of the full table.

module fft_twiddle_lane #(
  parameter int STAGES = 2,
  parameter int W_BIT  = 12
) (
  input  logic                      iCLK,
  input  logic                      iRESET,
  input  logic                      en,
  input  logic [2*STAGES-1:0]       addr,
  output logic signed [W_BIT-1:0]   re,
  output logic signed [W_BIT-1:0]   im
);
  localparam int N   = 1 << (2*STAGES);
  localparam int NQ  = N / 4;
  localparam int QW  = 2*STAGES - 1;
  localparam int AMP = (1 << (W_BIT-1)) - 1;

  // round(cos(2*pi*k/N) * AMP) for 0 <= k <= N/4, Taylor series in Q30 fixed point
  function automatic logic [W_BIT-1:0] cmag(input int k);
    longint x, x2, term, sum;
    x    = (64'sd6746518852 * longint'(k)) / longint'(N);
    x2   = (x * x) >>> 30;
    term = 64'sd1 <<< 30;
    sum  = term;
    for (int n = 1; n <= 8; n++) begin
      term = -(((term * x2) >>> 30) / longint'((2*n-1) * (2*n)));
      sum  = sum + term;
    end
    if (sum < 0) sum = 0;
    return W_BIT'(((sum * longint'(AMP)) + (64'sd1 <<< 29)) >>> 30);
  endfunction

  logic signed [W_BIT-1:0] re_d, im_d;

`ifdef TWIDDLE_QUARTER_ROM_EN
  logic [W_BIT-1:0]        qrom [NQ+1];
  logic [1:0]              q;
  logic [QW-1:0]           ri, si;
  logic signed [W_BIT-1:0] c, s;

  for (genvar k = 0; k <= NQ; k++) begin : g_qrom
    assign qrom[k] = cmag(k);
  end

  // cos/-sin of quadrant q rebuilt from C[r] and C[N/4-r]
  always_comb begin
    q  = addr[2*STAGES-1 -: 2];
    ri = {1'b0, addr[2*STAGES-3:0]};
    si = QW'(NQ) - ri;
    c  = signed'(qrom[ri]);
    s  = signed'(qrom[si]);
    case (q)
      2'd0:    begin re_d = c;  im_d = -s; end
      2'd1:    begin re_d = -s; im_d = -c; end
      2'd2:    begin re_d = -c; im_d = s;  end
      default: begin re_d = s;  im_d = c;  end
    endcase
  end
`else
  function automatic logic [2*W_BIT-1:0] rom_word(input int k);
    logic signed [W_BIT-1:0] c, s;
    c = signed'(cmag(k % NQ));
    s = signed'(cmag(NQ - (k % NQ)));
    case (k / NQ)
      0:       rom_word = {c, -s};
      1:       rom_word = {-s, -c};
      2:       rom_word = {-c, s};
      default: rom_word = {s, c};
    endcase
  endfunction

  logic [2*W_BIT-1:0] rom [N];

  for (genvar k = 0; k < N; k++) begin : g_rom
    assign rom[k] = rom_word(k);
  end

  assign {re_d, im_d} = rom[addr];
`endif

  always_ff @(posedge iCLK or negedge iRESET)
    if (!iRESET) begin
      re <= '0;
      im <= '0;
    end else if (en) begin
      re <= re_d;
      im <= im_d;
    end
endmodule

module fft_twiddle_gen #(
  parameter int STAGES = 2,
  parameter int W_BIT  = 12
) (
  input  logic                           iCLK,
  input  logic                           iRESET,
  input  logic                           iSTART,
  input  logic [$clog2(STAGES+1)-1:0]    iSTAGE,
  input  logic                           iEN,
  output logic signed [W_BIT-1:0]        oW1_RE,
  output logic signed [W_BIT-1:0]        oW1_IM,
  output logic signed [W_BIT-1:0]        oW2_RE,
  output logic signed [W_BIT-1:0]        oW2_IM,
  output logic signed [W_BIT-1:0]        oW3_RE,
  output logic signed [W_BIT-1:0]        oW3_IM,
  output logic [2*STAGES-3:0]            oIDX,
  output logic                           oVALID,
  output logic                           oBUSY,
  output logic                           oDONE,
  output logic                           oERR
);
  // iSTAGE is one bit wider than strictly needed so out-of-range stages can be flagged
  localparam int SW    = $clog2(STAGES+1);
  localparam int LOG2N = 2*STAGES;
  localparam int BW    = 2*STAGES - 2;
  localparam int NB    = 1 << BW;
  localparam int LAT   = 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                      state, state_nxt;
  logic [BW-1:0]               b, b_nxt, idx_q;
  logic [SW-1:0]               s, s_nxt;
  logic                        err_nxt, req, last_req, last_q;
  logic [LAT:1]                vld_pipe;
  logic [2:0][LOG2N-1:0]       addr_d, addr_q;
  logic [LOG2N-1:0]            mask, e1;
  logic [2:0][W_BIT-1:0]       w_re, w_im;

  assign req      = (state == RUN) && iEN;
  assign last_req = req && (b == BW'(NB-1));

  always_comb begin
    state_nxt = state;
    b_nxt     = b;
    s_nxt     = s;
    err_nxt   = 1'b0;
    case (state)
      IDLE:
        if (iSTART) begin
          if (int'(iSTAGE) < STAGES) begin
            state_nxt = RUN;
            s_nxt     = iSTAGE;
            b_nxt     = '0;
          end else begin
            err_nxt = 1'b1;
          end
        end
      RUN:
        if (req) begin
          b_nxt = b + 1'b1;
          if (last_req) state_nxt = DRAIN;
        end
      DRAIN:
        if (!vld_pipe[1]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // e = (b mod 4^(STAGES-1-s)) << 2s; multiples wrap mod N by truncation
  always_comb begin
    mask      = LOG2N'((1 << (2*(STAGES-1-int'(s)))) - 1);
    e1        = (LOG2N'(b) & mask) << (2*int'(s));
    addr_d[0] = e1;
    addr_d[1] = e1 << 1;
    addr_d[2] = e1 + (e1 << 1);
  end

  always_ff @(posedge iCLK or negedge iRESET)
    if (!iRESET) begin
      state    <= IDLE;
      b        <= '0;
      s        <= '0;
      vld_pipe <= '0;
      addr_q   <= '0;
      idx_q    <= '0;
      last_q   <= 1'b0;
      oIDX     <= '0;
      oDONE    <= 1'b0;
      oERR     <= 1'b0;
    end else begin
      state    <= state_nxt;
      b        <= b_nxt;
      s        <= s_nxt;
      vld_pipe <= {vld_pipe[LAT-1:1], req};
      if (req) begin
        addr_q <= addr_d;
        idx_q  <= b;
        last_q <= last_req;
      end
      if (vld_pipe[1]) oIDX <= idx_q;
      oDONE <= vld_pipe[1] && last_q;
      oERR  <= err_nxt;
    end

  for (genvar l = 0; l < 3; l++) begin : g_lane
    fft_twiddle_lane #(.STAGES(STAGES), .W_BIT(W_BIT)) u_lane (
      .iCLK   (iCLK),
      .iRESET (iRESET),
      .en     (vld_pipe[1]),
      .addr   (addr_q[l]),
      .re     (w_re[l]),
      .im     (w_im[l])
    );
  end

  assign oW1_RE = w_re[0];
  assign oW1_IM = w_im[0];
  assign oW2_RE = w_re[1];
  assign oW2_IM = w_im[1];
  assign oW3_RE = w_re[2];
  assign oW3_IM = w_im[2];
  assign oVALID = vld_pipe[LAT];
  assign oBUSY  = (state != IDLE);
endmodule

// File: tb/tb_fft_twiddle_gen.sv
// Directed bench for fft_twiddle_gen at STAGES=2, N=16, W_BIT=12 (1.0 = 2047).
module tb_fft_twiddle_gen;
  logic              iCLK = 1'b0;
  logic              iRESET, iSTART, iEN;
  logic [1:0]        iSTAGE;
  logic signed [11:0] w1r, w1i, w2r, w2i, w3r, w3i;
  logic [1:0]        oidx;
  logic              ovalid, obusy, odone, oerr;

  int n_chk  = 0;
  int n_fail = 0;

  // stage-0 triples per butterfly b: W^b, W^2b, W^3b
  int exp_re [4][3] = '{'{2047, 2047, 2047}, '{1891, 1447, 783},
                        '{1447, 0, -1447},   '{783, -1447, -1891}};
  int exp_im [4][3] = '{'{0, 0, 0},          '{-783, -1447, -1891},
                        '{-1447, -2047, -1447}, '{-1891, -1447, 783}};

  always #5 iCLK = ~iCLK;

  fft_twiddle_gen #(.STAGES(2), .W_BIT(12)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iSTART(iSTART), .iSTAGE(iSTAGE), .iEN(iEN),
    .oW1_RE(w1r), .oW1_IM(w1i), .oW2_RE(w2r), .oW2_IM(w2i), .oW3_RE(w3r), .oW3_IM(w3i),
    .oIDX(oidx), .oVALID(ovalid), .oBUSY(obusy), .oDONE(odone), .oERR(oerr)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "/w1r"}, int'(w1r), 0);
    check({tag, "/w1i"}, int'(w1i), 0);
    check({tag, "/w2r"}, int'(w2r), 0);
    check({tag, "/w2i"}, int'(w2i), 0);
    check({tag, "/w3r"}, int'(w3r), 0);
    check({tag, "/w3i"}, int'(w3i), 0);
    check({tag, "/idx"}, int'(oidx), 0);
    check({tag, "/vld"}, int'(ovalid), 0);
    check({tag, "/busy"}, int'(obusy), 0);
    check({tag, "/done"}, int'(odone), 0);
    check({tag, "/err"}, int'(oerr), 0);
  endtask

  task automatic check_twid(input string tag, input int stg, input int idx);
    int ar [3];
    int ai [3];
    ar = '{int'(w1r), int'(w2r), int'(w3r)};
    ai = '{int'(w1i), int'(w2i), int'(w3i)};
    check({tag, "/idx"}, int'(oidx), idx);
    for (int l = 0; l < 3; l++) begin
      check($sformatf("%s/b%0d/w%0d_re", tag, idx, l+1), ar[l], (stg == 0) ? exp_re[idx][l] : 2047);
      check($sformatf("%s/b%0d/w%0d_im", tag, idx, l+1), ai[l], (stg == 0) ? exp_im[idx][l] : 0);
    end
  endtask

  // Start a stage, then drive iEN from en_pat one bit per cycle; mid >= 0 pulses an ignored iSTART
  task automatic run_stage(input string tag, input int stg, input logic [15:0] en_pat,
                           input int nsteps, input int mid);
    int  nreq = 0, nout = 0, held = -1;
    bit  prev = 0, cur, dn, done_seen = 0;
    iSTAGE = 2'(stg);
    iSTART = 1'b1;
    iEN    = 1'b0;
    step();
    iSTART = 1'b0;
    check({tag, "/busy@start"}, int'(obusy), 1);
    for (int k = 0; k < nsteps; k++) begin
      iEN = en_pat[k];
      cur = en_pat[k] && (nreq < 4);
      if (cur) nreq++;
      if (k == mid) begin
        iSTART = 1'b1;
        iSTAGE = (stg == 0) ? 2'd1 : 2'd0;
      end
      step();
      iSTART = 1'b0;
      if (prev) begin
        held = nout;
        nout++;
      end
      dn = prev && (held == 3);
      check($sformatf("%s/k%0d/vld", tag, k), int'(ovalid), int'(prev));
      check($sformatf("%s/k%0d/done", tag, k), int'(odone), int'(dn));
      check($sformatf("%s/k%0d/busy", tag, k), int'(obusy), int'(!done_seen));
      check($sformatf("%s/k%0d/err", tag, k), int'(oerr), 0);
      if (held >= 0) check_twid($sformatf("%s/k%0d", tag, k), stg, held);
      if (dn) done_seen = 1;
      prev = cur;
    end
    iEN = 1'b0;
  endtask

  initial begin
    iRESET = 1'b0;
    iSTART = 1'b0;
    iEN    = 1'b0;
    iSTAGE = 2'd0;

    // reset with random inputs, then release
    for (int c = 0; c < 4; c++) begin
      iSTART = 1'($urandom);
      iEN    = 1'($urandom);
      iSTAGE = 2'($urandom);
      step();
      check_zero($sformatf("rst%0d", c));
    end
    iSTART = 1'b0;
    iEN    = 1'b0;
    iSTAGE = 2'd0;
    iRESET = 1'b1;
    step();
    step();
    check_zero("post_rst");

    // stage 0, back-to-back requests
    run_stage("s0", 0, 16'h000F, 6, -1);
    // stage 1, all twiddles 1.0
    run_stage("s1", 1, 16'h000F, 6, -1);
    // stage 0 with a one-cycle request gap
    run_stage("gap", 0, 16'h001D, 7, -1);

    // out-of-range stage while idle
    for (int st = 2; st < 4; st++) begin
      iSTAGE = 2'(st);
      iSTART = 1'b1;
      step();
      iSTART = 1'b0;
      check($sformatf("err%0d/pulse", st), int'(oerr), 1);
      check($sformatf("err%0d/busy", st), int'(obusy), 0);
      step();
      check($sformatf("err%0d/clear", st), int'(oerr), 0);
      check($sformatf("err%0d/busy2", st), int'(obusy), 0);
    end
    // iSTART during RUN is ignored
    run_stage("midstart", 0, 16'h000F, 6, 1);

    // reset asserted after two requests
    iSTAGE = 2'd0;
    iSTART = 1'b1;
    step();
    iSTART = 1'b0;
    iEN    = 1'b1;
    step();
    step();
    check("midrst/vld_before", int'(ovalid), 1);
    #2;
    iRESET = 1'b0;
    iEN    = 1'b0;
    #1;
    check_zero("midrst");
    step();
    iRESET = 1'b1;
    step();
    check("midrst/nodone1", int'(odone), 0);
    check("midrst/busy1", int'(obusy), 0);
    step();
    check("midrst/nodone2", int'(odone), 0);
    check("midrst/vld2", int'(ovalid), 0);
    run_stage("after_rst", 0, 16'h000F, 6, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
